// File: rtl/instr_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// instr_sequencer_pkg
//
// Shared definitions for the OSECPU control unit and its datapath:
//   - sequencer state codes (4 bits wide, the width the datapath decodes)
//   - opcode constants for the instruction set
//   - small helper to pull the opcode field out of an instruction word
// ----------------------------------------------------------------------------
package instr_sequencer_pkg;

    // Width of current_state; the datapath decodes the same width.
    localparam int STATE_WIDTH = 4;

    // Sequencer state codes, shared with the datapath decoder.
    localparam logic [STATE_WIDTH-1:0] STATE_HLT   = 4'd0;
    localparam logic [STATE_WIDTH-1:0] STATE_FETCH = 4'd1;
    localparam logic [STATE_WIDTH-1:0] STATE_EXEC  = 4'd2;
    localparam logic [STATE_WIDTH-1:0] STATE_OUT   = 4'd3;

    // Control and load opcodes.
    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_LIMM16 = 8'h02;
    localparam logic [7:0] OP_CP     = 8'h10;
    localparam logic [7:0] OP_DBGD2  = 8'hd2;
    localparam logic [7:0] OP_CPDR   = 8'hd3;
    localparam logic [7:0] OP_END    = 8'hff;

    // ALU opcodes. CP is encoded as an OR of a register with itself,
    // so OP_CP and OP_OR share the same value.
    localparam logic [7:0] OP_OR  = 8'h10;
    localparam logic [7:0] OP_XOR = 8'h11;
    localparam logic [7:0] OP_AND = 8'h12;
    localparam logic [7:0] OP_ADD = 8'h14;
    localparam logic [7:0] OP_SUB = 8'h15;
    localparam logic [7:0] OP_SHL = 8'h18;
    localparam logic [7:0] OP_SAR = 8'h19;

    // Opcode field of an instruction word.
    function automatic logic [7:0] opcode_of(input logic [31:0] instr);
        return instr[31:24];
    endfunction

endpackage

// File: rtl/instr_sequencer_decode.sv
// ----------------------------------------------------------------------------
// instr_decode
//
// Purely combinational opcode classifier used by the sequencer during EXEC.
//
// Ports:
//   op        in  8  opcode field of the current instruction
//   is_legal  out 1  opcode is part of the supported instruction set
//   is_end    out 1  opcode is END (normal halt)
//   is_cpdr   out 1  opcode is CPDR (emit a debug word)
// ----------------------------------------------------------------------------
module instr_decode
    import instr_sequencer_pkg::*;
(
    input  logic [7:0] op,
    output logic       is_legal,
    output logic       is_end,
    output logic       is_cpdr
);

    // Classify the opcode. Anything not listed falls to the default arm and
    // is reported as illegal, which makes the sequencer halt with err set.
    always_comb begin
        is_legal = 1'b0;
        is_end   = 1'b0;
        is_cpdr  = 1'b0;
        case (op)
            OP_NOP,
            OP_LIMM16,
            OP_OR,
            OP_XOR,
            OP_AND,
            OP_ADD,
            OP_SUB,
            OP_SHL,
            OP_SAR,
            OP_DBGD2: begin
                is_legal = 1'b1;
            end
            OP_CPDR: begin
                is_legal = 1'b1;
                is_cpdr  = 1'b1;
            end
            OP_END: begin
                is_legal = 1'b1;
                is_end   = 1'b1;
            end
            default: begin
                is_legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// ----------------------------------------------------------------------------
// instr_sequencer
//
// Top-level control unit of the OSECPU FPGA core. Fetches instruction words
// over a req/ack handshake, holds the current word for the datapath, steps
// each instruction through FETCH -> EXEC (-> OUT for CPDR) and halts on END
// or on an unsupported opcode.
//
// Parameters:
//   PC_WIDTH   width of the program counter and fetch address
//   RESET_PC   address loaded into pc when run is accepted
//
// Ports:
//   clk            in   1         system clock, rising edge
//   rst_n          in   1         asynchronous active-low reset
//   run            in   1         start pulse, only honoured while halted
//   mem_req        out  1         fetch request
//   mem_addr       out  PC_WIDTH  fetch address (equal to pc)
//   mem_ack        in   1         fetch data valid this cycle
//   mem_rdata      in   32        fetched instruction word
//   instr0         out  32        current instruction for the datapath
//   current_state  out  4         sequencer state for the datapath
//   pc             out  PC_WIDTH  address of the next fetch
//   ireg_d0        in   32        datapath register read port 0
//   dbg_valid      out  1         debug word available
//   dbg_data       out  32        debug word (CPDR operand value)
//   dbg_ready      in   1         debug sink accepts the word
//   halted         out  1         sequencer is in the halt state
//   err            out  1         sticky: halted on an unsupported opcode
// ----------------------------------------------------------------------------
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int                  PC_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   run,
    output logic                   mem_req,
    output logic [PC_WIDTH-1:0]    mem_addr,
    input  logic                   mem_ack,
    input  logic [31:0]            mem_rdata,
    output logic [31:0]            instr0,
    output logic [STATE_WIDTH-1:0] current_state,
    output logic [PC_WIDTH-1:0]    pc,
    input  logic [31:0]            ireg_d0,
    output logic                   dbg_valid,
    output logic [31:0]            dbg_data,
    input  logic                   dbg_ready,
    output logic                   halted,
    output logic                   err
);

    logic [STATE_WIDTH-1:0] state_q;
    logic [STATE_WIDTH-1:0] state_d;
    logic                   is_legal;
    logic                   is_end;
    logic                   is_cpdr;

    instr_decode u_decode (
        .op       (opcode_of(instr0)),
        .is_legal (is_legal),
        .is_end   (is_end),
        .is_cpdr  (is_cpdr)
    );

    // Next-state logic. Inputs that have no meaning in the current state
    // (run outside HLT, mem_ack outside FETCH, dbg_ready outside OUT) are
    // simply never looked at. EXEC always lasts one cycle: the datapath
    // commits its register write on the edge that leaves EXEC.
    always_comb begin
        state_d = state_q;
        case (state_q)
            STATE_HLT: begin
                if (run) begin
                    state_d = STATE_FETCH;
                end
            end
            STATE_FETCH: begin
                if (mem_ack) begin
                    state_d = STATE_EXEC;
                end
            end
            STATE_EXEC: begin
                if (!is_legal || is_end) begin
                    state_d = STATE_HLT;
                end else if (is_cpdr) begin
                    state_d = STATE_OUT;
                end else begin
                    state_d = STATE_FETCH;
                end
            end
            STATE_OUT: begin
                if (dbg_ready) begin
                    state_d = STATE_FETCH;
                end
            end
            default: begin
                state_d = STATE_HLT;
            end
        endcase
    end

    // State register. Reset drops straight to HLT, abandoning any fetch or
    // debug transfer in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STATE_HLT;
        end else begin
            state_q <= state_d;
        end
    end

    // Program counter. Reloaded on an accepted run, advanced once per
    // completed fetch; it wraps naturally at 2^PC_WIDTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else if (state_q == STATE_HLT && run) begin
            pc <= RESET_PC;
        end else if (state_q == STATE_FETCH && mem_ack) begin
            pc <= pc + 1'b1;
        end
    end

    // Instruction register. Only the acknowledged word is captured, so the
    // datapath sees a stable instr0 through wait states and EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr0 <= '0;
        end else if (state_q == STATE_FETCH && mem_ack) begin
            instr0 <= mem_rdata;
        end
    end

    // Debug word register. CPDR's operand is on ireg_d0 during EXEC; it is
    // captured there and then held for as long as the sink back-pressures.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_data <= '0;
        end else if (state_q == STATE_EXEC && is_cpdr) begin
            dbg_data <= ireg_d0;
        end
    end

    // Sticky error flag. Set when EXEC meets an unsupported opcode, cleared
    // only by the next accepted run (or reset).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (state_q == STATE_HLT && run) begin
            err <= 1'b0;
        end else if (state_q == STATE_EXEC && !is_legal) begin
            err <= 1'b1;
        end
    end

    // Outputs decoded purely from registered state; no input reaches an
    // output combinationally.
    assign current_state = state_q;
    assign mem_req       = (state_q == STATE_FETCH);
    assign mem_addr      = pc;
    assign dbg_valid     = (state_q == STATE_OUT);
    assign halted        = (state_q == STATE_HLT);

endmodule
